// File: rtl/gen_tk2_inv_pkg.sv
// Shared definitions for the inverse TK2 tweakey schedule generator:
// default round count, cell permutation tables, FSM state encoding.
package gen_tk2_inv_pkg;

    localparam int ROUNDS_DEF = 40;
    localparam int NCELL      = 16;

    // Entry i (cell i sits in the top nibble for i=0) names the source
    // cell feeding output cell i.
    localparam logic [63:0] P_FWD = {
        4'd9, 4'd15, 4'd8, 4'd13, 4'd10, 4'd14, 4'd12, 4'd11,
        4'd0, 4'd1,  4'd2, 4'd3,  4'd4,  4'd5,  4'd6,  4'd7
    };

    localparam logic [63:0] P_INV = {
        4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15,
        4'd2, 4'd0, 4'd4,  4'd7,  4'd6,  4'd3,  4'd5,  4'd1
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    function automatic int perm_src(input logic [63:0] tbl, input int i);
        return 32'(tbl[63-4*i -: 4]);
    endfunction

endpackage

// File: rtl/tk2_lfsr.sv
// TK2 LFSR on cells 0..7: (x7..x0) -> (x6..x0, x7^x5); cells 8..15 pass.
// Ports: din (16-cell state), dout (state after LFSR2).
module tk2_lfsr
    import gen_tk2_inv_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [16*W-1:0] din,
    output logic [16*W-1:0] dout
);

    always_comb begin
        dout = din;
        for (int i = 0; i < 8; i++) begin
            dout[(NCELL-1-i)*W +: W] = {
                din[(NCELL-1-i)*W +: W-1],
                din[(NCELL-1-i)*W+W-1] ^ din[(NCELL-1-i)*W+W-3]
            };
        end
    end

endmodule

// File: rtl/tweak_perm.sv
// Forward tweakey cell permutation: output cell i = input cell P[i].
// Ports: din (16 cells, cell 0 in MSBs), dout (permuted state).
module tweak_perm
    import gen_tk2_inv_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [16*W-1:0] din,
    output logic [16*W-1:0] dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < NCELL; i++) begin
            dout[(NCELL-1-i)*W +: W] =
                din[(NCELL-1-perm_src(P_FWD, i))*W +: W];
        end
    end

endmodule

// File: rtl/tweak_perm_inv.sv
// Inverse tweakey step: inverse LFSR2 on cells 0..7, then P^-1.
// Ports: din (16-cell state), dout (state one round earlier).
module tweak_perm_inv
    import gen_tk2_inv_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [16*W-1:0] din,
    output logic [16*W-1:0] dout
);

    logic [16*W-1:0] lfsr_inv;

    // (y7..y0) -> (y0^y6, y7..y1) undoes the forward shift-left LFSR
    always_comb begin
        lfsr_inv = din;
        for (int i = 0; i < 8; i++) begin
            lfsr_inv[(NCELL-1-i)*W +: W] = {
                din[(NCELL-1-i)*W] ^ din[(NCELL-1-i)*W+W-2],
                din[(NCELL-1-i)*W+W-1 -: W-1]
            };
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < NCELL; i++) begin
            dout[(NCELL-1-i)*W +: W] =
                lfsr_inv[(NCELL-1-perm_src(P_INV, i))*W +: W];
        end
    end

endmodule

// File: rtl/gen_tk2_inv.sv
// Inverse TK2 schedule: runs forward to the last round, then releases
// round keys ROUNDS-1..0 on a valid/ready handshake.
// Ports: clk, rst_n (async low), start, tk2_init, ready in;
// tk2_round, round_idx, valid, busy out (all registered).
// Option GEN_TK2_INV_PRELOAD_EN adds load_last/tk2_last to skip FWD.
module gen_tk2_inv
    import gen_tk2_inv_pkg::*;
#(
    parameter int W      = 8,
    parameter int ROUNDS = ROUNDS_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [16*W-1:0] tk2_init,
`ifdef GEN_TK2_INV_PRELOAD_EN
    input  logic            load_last,
    input  logic [16*W-1:0] tk2_last,
`endif
    output logic [16*W-1:0] tk2_round,
    output logic [5:0]      round_idx,
    output logic            valid,
    input  logic            ready,
    output logic            busy
);

    localparam logic [5:0] IDX_LAST = 6'(ROUNDS - 1);
    localparam logic [5:0] IDX_PRE  = 6'(ROUNDS - 2);

    state_e          state_q, state_d;
    logic [16*W-1:0] tk_q, tk_d;
    logic [5:0]      idx_q, idx_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;

    logic [16*W-1:0] perm_st;
    logic [16*W-1:0] fwd_st;
    logic [16*W-1:0] inv_st;

    tweak_perm #(.W(W)) u_perm (
        .din  (tk_q),
        .dout (perm_st)
    );

    tk2_lfsr #(.W(W)) u_lfsr (
        .din  (perm_st),
        .dout (fwd_st)
    );

    tweak_perm_inv #(.W(W)) u_inv (
        .din  (tk_q),
        .dout (inv_st)
    );

    always_comb begin
        state_d = state_q;
        tk_d    = tk_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        unique case (state_q)
            S_IDLE: begin
`ifdef GEN_TK2_INV_PRELOAD_EN
                if (load_last) begin
                    tk_d    = tk2_last;
                    idx_d   = IDX_LAST;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_OUT;
                end else
`endif
                if (start) begin
                    tk_d    = tk2_init;
                    idx_d   = 6'd0;
                    busy_d  = 1'b1;
                    state_d = S_FWD;
                end
            end
            S_FWD: begin
                tk_d  = fwd_st;
                idx_d = idx_q + 6'd1;
                // the counter lands on ROUNDS-1 together with the state
                if (idx_q == IDX_PRE) begin
                    valid_d = 1'b1;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (ready) begin
                    if (idx_q != 6'd0) begin
                        tk_d  = inv_st;
                        idx_d = idx_q - 6'd1;
                    end else begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tk_q    <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tk_q    <= tk_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign tk2_round = tk_q;
    assign round_idx = idx_q;
    assign valid     = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_gen_tk2_inv.sv
// Self-checking bench for gen_tk2_inv against a byte-level model of
// the forward TK2 schedule; also exercises tweak_perm_inv directly.
module tb_gen_tk2_inv;

    localparam int R = 40;

    int p_tab [16] = '{9, 15, 8, 13, 10, 14, 12, 11,
                       0, 1, 2, 3, 4, 5, 6, 7};

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         ready = 1'b0;
    logic [127:0] tk2_init = '0;
`ifdef GEN_TK2_INV_PRELOAD_EN
    logic         load_last = 1'b0;
    logic [127:0] tk2_last = '0;
`endif
    logic [127:0] tk2_round;
    logic [5:0]   round_idx;
    logic         valid;
    logic         busy;

    logic [127:0] inv_din = '0;
    logic [127:0] inv_dout;

    int checks = 0;
    int errors = 0;
    logic [127:0] sched [R];

    always #5 clk = ~clk;

    gen_tk2_inv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .tk2_init  (tk2_init),
`ifdef GEN_TK2_INV_PRELOAD_EN
        .load_last (load_last),
        .tk2_last  (tk2_last),
`endif
        .tk2_round (tk2_round),
        .round_idx (round_idx),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy)
    );

    tweak_perm_inv u_inv_only (
        .din  (inv_din),
        .dout (inv_dout)
    );

    function automatic logic [127:0] fwd_model(input logic [127:0] s);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        for (int i = 0; i < 16; i++) b[i] = a[p_tab[i]];
        for (int i = 0; i < 8; i++) begin
            int x;
            x = int'(b[i]);
            b[i] = 8'(((x * 2) % 256) + (((x / 128) ^ (x / 32)) % 2));
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r;
    endfunction

    task automatic build_sched(input logic [127:0] init);
        sched[0] = init;
        for (int r = 1; r < R; r++) sched[r] = fwd_model(sched[r-1]);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_key"}, tk2_round, 128'h0);
        chk({tag, "_idx"}, 128'(round_idx), 128'h0);
        chk({tag, "_valid"}, 128'(valid), 128'h0);
        chk({tag, "_busy"}, 128'(busy), 128'h0);
    endtask

    // Full schedule from sched[0]; stall_pct = percent of cycles with
    // ready low; poke drives random start pulses while busy.
    task automatic run_sched(input int stall_pct, input bit poke);
        int lat;
        int exp_idx;
        bit acc;
        tk2_init = sched[0];
        start = 1'b1;
        tick;
        start = 1'b0;
        tk2_init = ~sched[0];
        chk("busy_after_start", 128'(busy), 128'h1);
        lat = 0;
        while (!valid && lat < 200) begin
            chk("busy_fwd", 128'(busy), 128'h1);
            if (poke) start = 1'($urandom_range(1));
            tick;
            lat++;
        end
        start = 1'b0;
        chk("latency", 128'(lat), 128'(R - 1));
        exp_idx = R - 1;
        for (int n = 0; n < 2000 && exp_idx >= 0; n++) begin
            ready = ($urandom_range(99) >= stall_pct);
            if (poke) start = 1'($urandom_range(1));
            chk("valid", 128'(valid), 128'h1);
            chk("busy_out", 128'(busy), 128'h1);
            chk("idx", 128'(round_idx), 128'(exp_idx));
            chk("key", tk2_round, sched[exp_idx]);
            acc = ready && valid;
            tick;
            if (acc) exp_idx--;
        end
        ready = 1'b0;
        start = 1'b0;
        chk("all_keys_out", 128'(exp_idx + 1), 128'h0);
        chk("valid_drop", 128'(valid), 128'h0);
        chk("busy_drop", 128'(busy), 128'h0);
    endtask

    initial begin
        logic [127:0] seq_init;
        logic [127:0] e;
        logic [127:0] s;

        seq_init = 128'h000102030405060708090a0b0c0d0e0f;
        build_sched(seq_init);

        #1 rst_n = 1'b0;
        #2 chk_reset_outs("reset");
        tick;
        rst_n = 1'b1;
        tick;
        chk_reset_outs("idle");

        // inverse LFSR2 on cell 0; P^-1 moves cell 0 to cell 9
        inv_din = {8'hFE, 120'h0};
        #1;
        e = '0;
        e[55:48] = 8'hFF;
        chk("inv_fe", inv_dout, e);
        inv_din = {8'h02, 120'h0};
        #1;
        e[55:48] = 8'h01;
        chk("inv_02", inv_dout, e);
        for (int k = 0; k < 1000; k++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            inv_din = fwd_model(s);
            #1;
            chk("inv_identity", inv_dout, s);
        end

        chk("sched_idx0", sched[0], seq_init);
        run_sched(0, 1'b0);
        tick;
        run_sched(30, 1'b0);
        run_sched(0, 1'b1);
        run_sched(30, 1'b1);

        build_sched({$urandom, $urandom, $urandom, $urandom});
        run_sched(30, 1'b0);

        // reset 20 cycles into the forward phase
        tk2_init = sched[0];
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (20) tick;
        rst_n = 1'b0;
        #1 chk_reset_outs("rst_fwd");
        tick;
        rst_n = 1'b1;
        run_sched(0, 1'b0);

        // reset partway through the output phase
        tk2_init = sched[0];
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int n = 0; n < 100 && !valid; n++) tick;
        ready = 1'b1;
        repeat (5) tick;
        chk("mid_out_idx", 128'(round_idx), 128'(R - 6));
        ready = 1'b0;
        rst_n = 1'b0;
        #1 chk_reset_outs("rst_out");
        tick;
        rst_n = 1'b1;
        build_sched(seq_init);
        run_sched(30, 1'b0);

`ifdef GEN_TK2_INV_PRELOAD_EN
        tk2_last = sched[R-1];
        tk2_init = ~sched[0];
        load_last = 1'b1;
        start = 1'b1;
        tick;
        load_last = 1'b0;
        start = 1'b0;
        chk("pre_valid", 128'(valid), 128'h1);
        chk("pre_busy", 128'(busy), 128'h1);
        for (int r = R - 1; r >= 0; r--) begin
            ready = 1'b1;
            chk("pre_idx", 128'(round_idx), 128'(r));
            chk("pre_key", tk2_round, sched[r]);
            tick;
        end
        ready = 1'b0;
        chk("pre_done", 128'(valid), 128'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
